// File: rtl/dmem_arbiter_if.sv
// Bundle between the core array/shared dmem and the data-memory arbiter.
// slave = arbiter side, master = cores plus memory side.
interface dmem_arbiter_if #(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 32
);
    localparam int MW = DATA_WIDTH / 8;

    logic [NUM_CORES-1:0]            req_re;
    logic [NUM_CORES-1:0]            req_we;
    logic [NUM_CORES*DATA_WIDTH-1:0] req_addr;
    logic [NUM_CORES*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_CORES*MW-1:0]         req_mask;
    logic [NUM_CORES-1:0]            req_lock;
    logic [NUM_CORES-1:0]            req_gnt;
    logic [NUM_CORES-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]           rsp_rdata;
    logic                            mem_re;
    logic                            mem_we;
    logic [DATA_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wdata;
    logic [MW-1:0]                   mem_mask;
    logic [DATA_WIDTH-1:0]           mem_rdata;
    logic                            mem_rresp;

    modport slave (
        input  req_re, req_we, req_addr, req_wdata, req_mask, req_lock,
        input  mem_rdata, mem_rresp,
        output req_gnt, rsp_valid, rsp_rdata,
        output mem_re, mem_we, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output req_re, req_we, req_addr, req_wdata, req_mask, req_lock,
        output mem_rdata, mem_rresp,
        input  req_gnt, rsp_valid, rsp_rdata,
        input  mem_re, mem_we, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter of NUM_CORES data-memory ports onto one shared dmem with AMO lock.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dmem_arbiter #(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          arst_n,
    dmem_arbiter_if.slave bus,
    output logic [1:0]    dbg_state,
    output logic          dbg_lock
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [PW-1:0]         rr_ptr, rr_next;
    logic [PW-1:0]         owner, owner_next;
    logic                  lock_active;
    logic [PW-1:0]         scan_base, win, srv;
    logic                  found, serve;
    logic [NUM_CORES-1:0]  active;

    logic [NUM_CORES-1:0]  gnt, rsp;
    logic [DATA_WIDTH-1:0] rdata, m_addr, m_wdata;
    logic [MW-1:0]         m_mask;
    logic                  m_re, m_we;

    logic [DATA_WIDTH-1:0] addr_a  [NUM_CORES];
    logic [DATA_WIDTH-1:0] wdata_a [NUM_CORES];
    logic [MW-1:0]         mask_a  [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign addr_a[i]  = bus.req_addr[i*DATA_WIDTH +: DATA_WIDTH];
        assign wdata_a[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign mask_a[i]  = bus.req_mask[i*MW +: MW];
    end

    // A simultaneous read and write from one core counts as a write only.
    assign active = bus.req_re | bus.req_we;

    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
        if (int'(v) >= NUM_CORES - 1) return '0;
        return v + PW'(1);
    endfunction

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    assign scan_base = rr_ptr;
`endif

    always_comb begin : scan
        int            idx;
        logic [PW-1:0] idx_p;
        idx   = 0;
        idx_p = '0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(scan_base) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            idx_p = PW'(idx);
            if (!found && active[idx_p]) begin
                found = 1'b1;
                win   = idx_p;
            end
        end
    end

    always_comb begin : ctrl
        state_next = state;
        rr_next    = rr_ptr;
        owner_next = owner;
        gnt        = '0;
        rsp        = '0;
        rdata      = '0;
        m_re       = 1'b0;
        m_we       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_mask     = '0;
        serve      = 1'b0;
        srv        = win;

        // Outputs stay quiet while reset is held, even with requests pending.
        if (arst_n) begin
            case (state)
                IDLE: serve = found;
                LOCKED: begin
                    if (active[owner]) begin
                        serve = 1'b1;
                        srv   = owner;
                    end else if (!bus.req_lock[owner]) begin
                        state_next = IDLE;
                    end
                end
                RD_WAIT: begin
                    m_re   = 1'b1;
                    m_addr = addr_a[owner];
                    m_mask = mask_a[owner];
                    if (bus.mem_rresp) begin
                        rsp[owner] = 1'b1;
                        rdata      = bus.mem_rdata;
                        rr_next    = inc_mod(owner);
                        state_next = bus.req_lock[owner] ? LOCKED : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        if (serve) begin
            gnt[srv] = 1'b1;
            m_addr   = addr_a[srv];
            m_mask   = mask_a[srv];
            if (bus.req_we[srv]) begin
                m_we       = 1'b1;
                m_wdata    = wdata_a[srv];
                rr_next    = inc_mod(srv);
                state_next = bus.req_lock[srv] ? LOCKED : IDLE;
                if (bus.req_lock[srv]) owner_next = srv;
            end else begin
                m_re       = 1'b1;
                owner_next = srv;
                // Zero-latency memory: finish the read in the issue cycle.
                if (bus.mem_rresp) begin
                    rsp[srv]   = 1'b1;
                    rdata      = bus.mem_rdata;
                    rr_next    = inc_mod(srv);
                    state_next = bus.req_lock[srv] ? LOCKED : IDLE;
                end else begin
                    state_next = RD_WAIT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            owner       <= '0;
            lock_active <= 1'b0;
        end else begin
            state       <= state_next;
            rr_ptr      <= rr_next;
            owner       <= owner_next;
            lock_active <= (state_next == LOCKED);
        end
    end

    assign bus.req_gnt   = gnt;
    assign bus.rsp_valid = rsp;
    assign bus.rsp_rdata = rdata;
    assign bus.mem_re    = m_re;
    assign bus.mem_we    = m_we;
    assign bus.mem_addr  = m_addr;
    assign bus.mem_wdata = m_wdata;
    assign bus.mem_mask  = m_mask;

    assign dbg_state = state;
    assign dbg_lock  = lock_active;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, randomized run against a reference model,
// and a reset-during-read sequence.
module tb_dmem_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int MW = DW / 8;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [1:0] dbg_state;
    logic       dbg_lock;

    dmem_arbiter_if #(.NUM_CORES(N), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(.NUM_CORES(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_lock  (dbg_lock)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_core(input int i, input logic re, input logic we, input logic lock,
                            input logic [DW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        bus.req_re[i]              = re;
        bus.req_we[i]              = we;
        bus.req_lock[i]            = lock;
        bus.req_addr[i*DW +: DW]   = a;
        bus.req_wdata[i*DW +: DW]  = d;
        bus.req_mask[i*MW +: MW]   = m;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) set_core(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        bus.mem_rresp = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  re, we, lock;
        logic        rresp;
        logic [31:0] rdata, a0, a1;
        logic [1:0]  e_gnt, e_rsp;
        logic        e_mre, e_mwe;
        logic [31:0] e_addr, e_rdata;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [1:0] re, input logic [1:0] we, input logic [1:0] lock,
                       input logic rr, input logic [31:0] rd, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [1:0] eg, input logic [1:0] er, input logic emr, input logic emw,
                       input logic [31:0] ea, input logic [31:0] erd);
        vec_t v;
        v.re = re; v.we = we; v.lock = lock; v.rresp = rr; v.rdata = rd; v.a0 = a0; v.a1 = a1;
        v.e_gnt = eg; v.e_rsp = er; v.e_mre = emr; v.e_mwe = emw; v.e_addr = ea; v.e_rdata = erd;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    int m_reader, m_lock_owner, m_next;
    logic [N-1:0]  e_gnt, e_rsp;
    logic [DW-1:0] e_rdata, e_addr, e_wdata;
    logic [MW-1:0] e_mask;
    logic          e_mre, e_mwe;

    task automatic model_reset();
        m_reader = -1; m_lock_owner = -1; m_next = 0;
    endtask

    function automatic logic [DW-1:0] core_addr(input int c);
        return bus.req_addr[c*DW +: DW];
    endfunction

    task automatic finish_read(input int c);
        e_rsp[c]     = 1'b1;
        e_rdata      = bus.mem_rdata;
        m_next       = (c + 1) % N;
        m_lock_owner = bus.req_lock[c] ? c : -1;
        m_reader     = -1;
    endtask

    task automatic model_step();
        int w;
        e_gnt = '0; e_rsp = '0; e_rdata = '0; e_addr = '0; e_wdata = '0; e_mask = '0;
        e_mre = 1'b0; e_mwe = 1'b0;
        w = -1;
        if (m_reader >= 0) begin
            e_mre  = 1'b1;
            e_addr = core_addr(m_reader);
            e_mask = bus.req_mask[m_reader*MW +: MW];
            if (bus.mem_rresp) finish_read(m_reader);
        end else begin
            if (m_lock_owner >= 0) begin
                if (bus.req_re[m_lock_owner] || bus.req_we[m_lock_owner]) w = m_lock_owner;
                else if (!bus.req_lock[m_lock_owner]) m_lock_owner = -1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = ((FIXED ? 0 : m_next) + k) % N;
                    if (w < 0 && (bus.req_re[c] || bus.req_we[c])) w = c;
                end
            end
            if (w >= 0) begin
                e_gnt[w] = 1'b1;
                e_addr   = core_addr(w);
                e_mask   = bus.req_mask[w*MW +: MW];
                if (bus.req_we[w]) begin
                    e_mwe        = 1'b1;
                    e_wdata      = bus.req_wdata[w*DW +: DW];
                    m_next       = (w + 1) % N;
                    m_lock_owner = bus.req_lock[w] ? w : -1;
                    exp_q.push_back(core_addr(w));
                end else begin
                    e_mre = 1'b1;
                    if (bus.mem_rresp) finish_read(w);
                    else m_reader = w;
                end
            end
        end
    endtask

    logic [N-1:0] pend;

    initial begin
        clear_inputs();
        model_reset();
        pend = '0;

        // ---- reset: outputs quiet even with a request present ----
        set_core(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA0, 4'h3);
        #12;
        chk("reset_gnt", bus.req_gnt, 0);
        chk("reset_mem_we", bus.mem_we, 0);
        chk("reset_state", dbg_state, 0);
        chk("reset_lock", dbg_lock, 0);
        clear_inputs();
        @(posedge clk); #1 arst_n = 1'b1;

        // ---- directed table ----
        add(2'b00, 2'b00, 2'b00, 1'b0, 32'h0,    32'h10, 32'h20, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  32'h0);
        add(2'b00, 2'b00, 2'b00, 1'b1, 32'h1234, 32'h10, 32'h20, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  32'h0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        for (int r = 0; r < 6; r++)
            add(2'b00, 2'b11, 2'b00, 1'b0, 32'h0, 32'h10, 32'h20, 2'b01, 2'b00, 1'b0, 1'b1, 32'h10, 32'h0);
        add(2'b00, 2'b10, 2'b00, 1'b0, 32'h0, 32'h10, 32'h20, 2'b10, 2'b00, 1'b0, 1'b1, 32'h20, 32'h0);
`else
        for (int r = 0; r < 2; r++) begin
            add(2'b00, 2'b11, 2'b00, 1'b0, 32'h0, 32'h10, 32'h20, 2'b01, 2'b00, 1'b0, 1'b1, 32'h10, 32'h0);
            add(2'b00, 2'b11, 2'b00, 1'b0, 32'h0, 32'h10, 32'h20, 2'b10, 2'b00, 1'b0, 1'b1, 32'h20, 32'h0);
        end
        add(2'b00, 2'b01, 2'b00, 1'b0, 32'h0, 32'h10, 32'h20, 2'b01, 2'b00, 1'b0, 1'b1, 32'h10, 32'h0);
        add(2'b10, 2'b01, 2'b00, 1'b0, 32'h0, 32'h10, 32'h40, 2'b10, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0);
        add(2'b10, 2'b01, 2'b00, 1'b0, 32'h0, 32'h10, 32'h40, 2'b00, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0);
        add(2'b10, 2'b01, 2'b00, 1'b0, 32'h0, 32'h10, 32'h40, 2'b00, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0);
        add(2'b10, 2'b01, 2'b00, 1'b1, 32'hDEADBEEF, 32'h10, 32'h40, 2'b00, 2'b10, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        add(2'b00, 2'b01, 2'b00, 1'b0, 32'h0, 32'h10, 32'h40, 2'b01, 2'b00, 1'b0, 1'b1, 32'h10, 32'h0);
        add(2'b01, 2'b10, 2'b01, 1'b0, 32'h0, 32'h80, 32'h20, 2'b10, 2'b00, 1'b0, 1'b1, 32'h20, 32'h0);
        add(2'b01, 2'b10, 2'b01, 1'b0, 32'h0, 32'h80, 32'h20, 2'b01, 2'b00, 1'b1, 1'b0, 32'h80, 32'h0);
        add(2'b01, 2'b10, 2'b01, 1'b1, 32'h55, 32'h80, 32'h20, 2'b00, 2'b01, 1'b1, 1'b0, 32'h80, 32'h55);
        add(2'b00, 2'b11, 2'b01, 1'b0, 32'h0, 32'h80, 32'h20, 2'b01, 2'b00, 1'b0, 1'b1, 32'h80, 32'h0);
        add(2'b00, 2'b10, 2'b01, 1'b0, 32'h0, 32'h80, 32'h20, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  32'h0);
        add(2'b00, 2'b10, 2'b00, 1'b0, 32'h0, 32'h80, 32'h20, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,  32'h0);
        add(2'b00, 2'b10, 2'b00, 1'b0, 32'h0, 32'h80, 32'h20, 2'b10, 2'b00, 1'b0, 1'b1, 32'h20, 32'h0);
`endif
        foreach (tbl[r]) begin
            logic [31:0] ew;
            set_core(0, tbl[r].re[0], tbl[r].we[0], tbl[r].lock[0], tbl[r].a0, 32'hA0, 4'h3);
            set_core(1, tbl[r].re[1], tbl[r].we[1], tbl[r].lock[1], tbl[r].a1, 32'hB0, 4'hC);
            bus.mem_rresp = tbl[r].rresp;
            bus.mem_rdata = tbl[r].rdata;
            ew = !tbl[r].e_mwe ? 32'h0 : (tbl[r].e_gnt[0] ? 32'hA0 : 32'hB0);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", r), bus.req_gnt, tbl[r].e_gnt);
            chk($sformatf("vec%0d_rsp", r), bus.rsp_valid, tbl[r].e_rsp);
            chk($sformatf("vec%0d_rdata", r), bus.rsp_rdata, tbl[r].e_rdata);
            chk($sformatf("vec%0d_mem_re", r), bus.mem_re, tbl[r].e_mre);
            chk($sformatf("vec%0d_mem_we", r), bus.mem_we, tbl[r].e_mwe);
            chk($sformatf("vec%0d_mem_addr", r), bus.mem_addr, tbl[r].e_addr);
            chk($sformatf("vec%0d_mem_wdata", r), bus.mem_wdata, ew);
            @(posedge clk); #1;
        end

        // ---- randomized run against the reference model ----
        clear_inputs();
        arst_n = 1'b0;
        #2 arst_n = 1'b1;
        model_reset();
        pend = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    int kind;
                    kind = $urandom_range(0, 3);
                    if (kind == 0) begin
                        set_core(i, 1'b0, 1'b0, $urandom_range(0, 3) == 0, '0, '0, '0);
                    end else begin
                        set_core(i, kind != 2, kind != 1, $urandom_range(0, 3) == 0,
                                 32'($urandom_range(0, 255)) << 2, $urandom, 4'($urandom_range(0, 15)));
                        pend[i] = 1'b1;
                    end
                end
            end
            bus.mem_rresp = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
            @(negedge clk);
            model_step();
            chk("rnd_gnt", bus.req_gnt, e_gnt);
            chk("rnd_rsp", bus.rsp_valid, e_rsp);
            chk("rnd_rdata", bus.rsp_rdata, e_rdata);
            chk("rnd_mem_re", bus.mem_re, e_mre);
            chk("rnd_mem_we", bus.mem_we, e_mwe);
            chk("rnd_mem_addr", bus.mem_addr, e_addr);
            chk("rnd_mem_wdata", bus.mem_wdata, e_wdata);
            chk("rnd_mem_mask", bus.mem_mask, e_mask);
            if (bus.mem_we) begin
                if (exp_q.size() == 0) chk("rnd_write_unexpected", 1, 0);
                else chk("rnd_write_order", bus.mem_addr, exp_q.pop_front());
            end
            for (int i = 0; i < N; i++)
                if (pend[i] && ((bus.req_gnt[i] && bus.req_we[i]) || bus.rsp_valid[i])) pend[i] = 1'b0;
            @(posedge clk); #1;
        end
        chk("rnd_write_q_empty", exp_q.size(), 0);

        // ---- reset during RD_WAIT drops the read ----
        clear_inputs();
        arst_n = 1'b0;
        @(posedge clk); #1 arst_n = 1'b1;
        set_core(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'hF);
        @(negedge clk);
        chk("rst_rd_issue_gnt", bus.req_gnt, 2'b10);
        chk("rst_rd_issue_re", bus.mem_re, 1);
        @(posedge clk); #1;
        chk("rst_rd_wait_state", dbg_state, 1);
        arst_n = 1'b0;
        set_core(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("rst_rd_state_idle", dbg_state, 0);
        chk("rst_rd_mem_re_low", bus.mem_re, 0);
        @(posedge clk); #1 arst_n = 1'b1;
        bus.mem_rresp = 1'b1;
        bus.mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("rst_late_rsp", bus.rsp_valid, 0);
        chk("rst_late_rdata", bus.rsp_rdata, 0);
        @(posedge clk); #1;
        bus.mem_rresp = 1'b0;
        set_core(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA0, 4'h3);
        @(negedge clk);
        chk("rst_next_gnt", bus.req_gnt, 2'b01);
        chk("rst_next_we", bus.mem_we, 1);
        chk("rst_next_addr", bus.mem_addr, 32'h10);
        @(posedge clk); #1;
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
